// File: rtl/aes_stim_misr.sv
`default_nettype none
// ============================================================================
//  Module   : aes_stim_misr
//  Purpose  : Plaintext/key stimulus generator for the AES benchmark tops.
//             Vectors are held, incremented, LFSR-stepped or directly loaded.
//             Counted bursts run under a small FSM, and the cipher responses
//             are compacted into a MISR signature.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_stim_misr #(
  parameter int              DW         = 128,
  parameter logic [DW-1:0]   POLY       = DW'(128'h87),
  parameter int              CNT_W      = 16,
  parameter int              TAP_STRIDE = 8,   // DW must be a multiple of this
  parameter int              TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,          // asynchronous, active low
  input  logic [1:0]               mode,
  input  logic                     state_change,
  input  logic                     key_change,
  input  logic                     load_valid,
  input  logic                     load_sel,
  input  logic [DW-1:0]            load_data,
  input  logic                     start,
  input  logic [CNT_W-1:0]         burst_len,
  input  logic [DW-1:0]            resp_in,
  input  logic                     resp_valid,
  output logic [DW-1:0]            state,
  output logic [DW-1:0]            key,
  output logic                     busy,
  output logic [DW-1:0]            signature,
  output logic                     sig_done,
  output logic                     err,
  output logic [DW/TAP_STRIDE-1:0] obs
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Drain timer must hold TIMEOUT-1.
  localparam int TO_W = $clog2(TIMEOUT) + 1;

  logic [1:0]       fsm;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] resp_count;
  logic [TO_W-1:0]  drain_count;

  logic             in_idle;
  logic             in_run;
  logic             in_drain;
  logic             start_ok;
  logic             resp_take;
  logic [CNT_W-1:0] resp_count_nx;
  logic             resp_complete;
  logic             last_issue;

  // Plain Galois shift; used by the MISR directly (no lock-up escape there).
  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
    return {x[DW-2:0], 1'b0} ^ (x[DW-1] ? POLY : '0);
  endfunction

  // Vector step for the current mode; the LFSR escapes the all-zero lock-up.
  function automatic logic [DW-1:0] step(input logic [1:0] m, input logic [DW-1:0] x);
    logic [DW-1:0] r;
    case (m)
      MODE_HOLD: r = x;
      MODE_INC:  r = x + DW'(1);
      MODE_LFSR: r = (x == '0) ? DW'(1) : lfsr_next(x);
      default:   r = x;   // load-only
    endcase
    return r;
  endfunction

  assign in_idle  = (fsm == S_IDLE);
  assign in_run   = (fsm == S_RUN);
  assign in_drain = (fsm == S_DRAIN);

  assign start_ok      = in_idle && start && (burst_len != '0);
  assign resp_take     = (in_run || in_drain) && resp_valid && (resp_count < burst_q);
  assign resp_count_nx = resp_count + CNT_W'(resp_take);
  // Includes a response arriving this cycle, so completion can be seen
  // on the final RUN cycle and skip DRAIN entirely.
  assign resp_complete = (resp_count_nx == burst_q);
  assign last_issue    = in_run && (issue_count == burst_q - CNT_W'(1));

  assign busy     = in_run || in_drain;
  assign sig_done = (fsm == S_DONE);

  // Burst control: vector issue count, drain timeout and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm         <= S_IDLE;
      burst_q     <= '0;
      issue_count <= '0;
      drain_count <= '0;
      err         <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start_ok) begin
            fsm         <= S_RUN;
            burst_q     <= burst_len;
            issue_count <= '0;
            drain_count <= '0;
            err         <= 1'b0;
          end
        end
        S_RUN: begin
          issue_count <= issue_count + CNT_W'(1);
          if (last_issue) begin
            fsm <= resp_complete ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (resp_complete) begin
            fsm <= S_DONE;
          end else if (drain_count == TO_W'(TIMEOUT - 1)) begin
            err <= 1'b1;
            fsm <= S_DONE;
          end else begin
            drain_count <= drain_count + TO_W'(1);
          end
        end
        default: fsm <= S_IDLE;   // DONE lasts exactly one cycle
      endcase
    end
  end

  // Plaintext register: IDLE load beats manual step; free-running step in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
    end else if (in_idle && load_valid && !load_sel) begin
      state <= load_data;
    end else if ((in_idle && state_change) || in_run) begin
      state <= step(mode, state);
    end
  end

  // Key register: steps in any state unless an IDLE key load takes the cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key <= '0;
    end else if (in_idle && load_valid && load_sel) begin
      key <= load_data;
    end else if (key_change) begin
      key <= step(mode, key);
    end
  end

  // MISR compaction of accepted responses; cleared only by a new burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature  <= '0;
      resp_count <= '0;
    end else if (start_ok) begin
      signature  <= '0;
      resp_count <= '0;
    end else if (resp_take) begin
      signature  <= lfsr_next(signature) ^ resp_in;
      resp_count <= resp_count_nx;
    end
  end

  // Sparse observation taps on the signature.
  generate
    for (genvar i = 0; i < DW / TAP_STRIDE; i++) begin : g_obs
      assign obs[i] = signature[i*TAP_STRIDE];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_aes_stim_misr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_stim_misr
//  Purpose  : Self-checking bench for aes_stim_misr: table of single-step
//             vectors plus hand-written burst, priority, timeout and reset
//             sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_stim_misr;

  localparam int DW    = 128;
  localparam int CNT_W = 16;
  localparam int TO    = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             state_change;
  logic             key_change;
  logic             load_valid;
  logic             load_sel;
  logic [DW-1:0]    load_data;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [DW-1:0]    resp_in;
  logic             resp_valid;
  logic [DW-1:0]    state;
  logic [DW-1:0]    key;
  logic             busy;
  logic [DW-1:0]    signature;
  logic             sig_done;
  logic             err;
  logic [DW/8-1:0]  obs;

  aes_stim_misr #(
    .DW(DW), .POLY(128'h87), .CNT_W(CNT_W), .TAP_STRIDE(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .state_change(state_change),
    .key_change(key_change), .load_valid(load_valid), .load_sel(load_sel),
    .load_data(load_data), .start(start), .burst_len(burst_len),
    .resp_in(resp_in), .resp_valid(resp_valid), .state(state), .key(key),
    .busy(busy), .signature(signature), .sig_done(sig_done), .err(err),
    .obs(obs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;
  int busy_cycles = 0;

  // Mid-cycle monitors for pulse and busy-duration counting.
  always @(negedge clk) begin
    if (rst && sig_done) done_pulses++;
    if (rst && busy)     busy_cycles++;
  end

  typedef struct {
    logic [1:0]    mode;
    logic          tgt;     // 0 = state, 1 = key
    logic [DW-1:0] init;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    state_change = 0; key_change = 0; load_valid = 0; load_sel = 0;
    load_data = '0; start = 0; burst_len = '0; resp_in = '0; resp_valid = 0;
  endtask

  task automatic do_load(input logic sel, input logic [DW-1:0] d);
    load_valid = 1; load_sel = sel; load_data = d;
    tick();
    load_valid = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (sig_done) begin
        seen = 1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: got no sig_done expected sig_done within %0d cycles", name, limit);
    end
  endtask

  logic [DW-1:0] r_tmo;
  int            snap;

  initial begin
    vecs[0] = '{2'b01, 1'b0, {DW{1'b1}},        128'h0};
    vecs[1] = '{2'b01, 1'b1, 128'h5,            128'h6};
    vecs[2] = '{2'b10, 1'b0, 128'h1,            128'h2};
    vecs[3] = '{2'b10, 1'b0, 128'h1 << 127,     128'h87};
    vecs[4] = '{2'b10, 1'b0, 128'h0,            128'h1};
    vecs[5] = '{2'b00, 1'b0, 128'h1234,         128'h1234};
    vecs[6] = '{2'b11, 1'b1, 128'habc,          128'habc};
    vecs[7] = '{2'b10, 1'b1, {1'b1, 126'h0, 1'b1}, 128'h85};
    vecs[8] = '{2'b01, 1'b0, 128'hff,           128'h100};

    idle_inputs();
    mode = 2'b00;
    rst  = 0;
    tick(); tick();
    check("reset_state", state, '0);
    check("reset_key", key, '0);
    check("reset_sig", signature, '0);
    check("reset_flags", {125'h0, busy, sig_done, err}, '0);
    rst = 1;
    tick();

    // Single-step table.
    for (int i = 0; i < 9; i++) begin
      mode = 2'b00;
      do_load(vecs[i].tgt, vecs[i].init);
      check($sformatf("vec%0d_load", i), vecs[i].tgt ? key : state, vecs[i].init);
      mode = vecs[i].mode;
      if (vecs[i].tgt) key_change = 1; else state_change = 1;
      tick();
      key_change = 0; state_change = 0;
      check($sformatf("vec%0d_step", i), vecs[i].tgt ? key : state, vecs[i].exp);
    end

    // IDLE load beats same-cycle step of the same register.
    mode = 2'b01;
    load_valid = 1; load_sel = 1; load_data = 128'h77; key_change = 1;
    tick();
    load_valid = 0; key_change = 0;
    check("prio_key", key, 128'h77);
    load_valid = 1; load_sel = 0; load_data = 128'h40; state_change = 1;
    tick();
    load_valid = 0; state_change = 0;
    check("prio_state", state, 128'h40);

    // start with burst_len = 0 is ignored.
    start = 1; burst_len = 0;
    tick();
    start = 0;
    check("zero_len_busy0", {127'h0, busy}, '0);
    tick();
    check("zero_len_busy1", {127'h0, busy}, '0);

    // Basic burst of 3, responses in DRAIN.
    do_load(0, '0);
    done_pulses = 0; busy_cycles = 0;
    start = 1; burst_len = 3;
    tick();
    start = 0;
    check("burst_busy", {127'h0, busy}, 128'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("burst_state%0d", i), state, DW'(i));
    end
    resp_valid = 1; resp_in = 128'h5; tick();
    resp_in = 128'h3; tick();
    resp_in = 128'h0; tick();
    resp_valid = 0;
    check("burst_sig_done", {127'h0, sig_done}, 128'h1);
    check("burst_sig", signature, 128'h12);
    check("burst_state_held", state, 128'h3);
    tick();
    check("burst_pulses", done_pulses, 1);
    check("burst_busy_cycles", busy_cycles, 6);
    resp_valid = 1; resp_in = 128'hff;
    tick();
    resp_valid = 0;
    check("idle_resp_ignored", signature, 128'h12);

    // Start/load/state_change ignored in RUN; responses complete in RUN.
    do_load(0, 128'h10);
    busy_cycles = 0;
    start = 1; burst_len = 4;
    tick();
    start = 1; burst_len = 9; load_valid = 1; load_sel = 0; load_data = 128'hdead;
    state_change = 1; resp_valid = 1; resp_in = '0;
    tick();
    start = 0; burst_len = 0; load_valid = 0; state_change = 0;
    check("run_ignore_state", state, 128'h11);
    wait_done("run_done", 20);
    resp_valid = 0;
    check("run_state_end", state, 128'h14);
    check("run_err", {127'h0, err}, '0);
    tick();
    check("run_busy_cycles", busy_cycles, 4);

    // Drain timeout with one of two responses.
    mode = 2'b00;
    r_tmo = {8'h01, 104'h0, 16'h0101};
    done_pulses = 0; busy_cycles = 0;
    start = 1; burst_len = 2;
    tick();
    start = 0; resp_valid = 1; resp_in = r_tmo;
    tick();
    resp_valid = 0;
    wait_done("tmo_done", TO + 50);
    check("tmo_err", {127'h0, err}, 128'h1);
    check("tmo_sig", signature, r_tmo);
    check("tmo_obs", {112'h0, obs}, 128'h8003);
    tick();
    check("tmo_busy_cycles", busy_cycles, 2 + TO);
    check("tmo_pulses", done_pulses, 1);
    check("tmo_err_sticky", {127'h0, err}, 128'h1);

    // Asynchronous reset in the middle of RUN.
    mode = 2'b01;
    start = 1; burst_len = 5;
    tick();
    start = 0;
    check("rst_err_cleared", {127'h0, err}, '0);
    resp_valid = 1; resp_in = 128'h9;
    tick();
    resp_valid = 0;
    tick();
    done_pulses = 0;
    #3 rst = 0;
    #1;
    check("arst_state", state, '0);
    check("arst_key", key, '0);
    check("arst_sig", signature, '0);
    check("arst_flags", {125'h0, busy, sig_done, err}, '0);
    tick(); tick();
    rst = 1;
    tick(); tick(); tick();
    check("arst_no_done", done_pulses, 0);
    check("arst_idle", {127'h0, busy}, '0);

    // The next burst behaves normally.
    start = 1; burst_len = 1;
    tick();
    start = 0; resp_valid = 1; resp_in = 128'h7;
    tick();
    resp_valid = 0;
    wait_done("post_rst_done", 10);
    check("post_rst_sig", signature, 128'h7);
    check("post_rst_state", state, 128'h1);
    tick();
    check("post_rst_pulses", done_pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
